// File: rtl/if_stage_if.sv
// Instruction-memory request/ack bus between the fetch stage and instruction memory.
interface if_stage_if;
    logic        req;
    logic [31:0] addr;
    logic        ack;
    logic [31:0] rdata;

    modport master (output req, output addr, input ack, input rdata);
    modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/if_stage.sv
// Instruction fetch stage: issues one outstanding imem read at a time and buffers
// fetched {pc, inst} pairs in a 2-entry FIFO presented to the IF/ID register.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_INC   = 32'd1
) (
    input  logic               clk,
    input  logic               rst_n,
    if_stage_if.master         imem,
    input  logic               stall,
    input  logic               redirect,
    input  logic [31:0]        redirect_pc,
    output logic [31:0]        PC_if,
    output logic [31:0]        inst_in,
    output logic               inst_valid
);
    localparam int unsigned XLEN = 32;
    localparam int unsigned CW   = 2;

    typedef enum logic [1:0] {IDLE, RUN, DROP} state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } entry_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] fetch_q, fetch_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic            req_q, req_d;
    logic [CW-1:0]   count_q, count_d;
    logic            rd_q, wr_q;
    entry_t          mem_q [2];
    entry_t          head;
    logic            ack_ok, push, pop, clear;

    // An ack only counts while a request is actually outstanding.
    assign ack_ok = imem.ack & req_q;

    // Next-state, FIFO control and request generation.
    always_comb begin
        state_d = state_q;
        fetch_d = fetch_q;
        push    = 1'b0;
        pop     = 1'b0;
        clear   = 1'b0;
        req_d   = 1'b0;
        addr_d  = addr_q;
        unique case (state_q)
            IDLE: begin
                state_d = RUN;
                if (redirect) begin
                    clear   = 1'b1;
                    fetch_d = redirect_pc;
                end
            end
            RUN: begin
                if (redirect) begin
                    clear   = 1'b1;
                    fetch_d = redirect_pc;
                    if (req_q && !ack_ok) state_d = DROP;
                end else begin
                    pop = inst_valid & ~stall;
                    if (ack_ok) begin
                        push    = 1'b1;
                        fetch_d = fetch_q + PC_INC;
                    end
                end
            end
            DROP: begin
                if (redirect) begin
                    clear   = 1'b1;
                    fetch_d = redirect_pc;
                end else begin
                    pop = inst_valid & ~stall;
                end
                if (ack_ok) state_d = RUN;
            end
            default: state_d = IDLE;
        endcase

        count_d = clear ? '0 : (count_q + CW'(push) - CW'(pop));

        // Hold an unacked request; otherwise start a new one when there is FIFO room.
        if (req_q && !ack_ok) begin
            req_d = 1'b1;
        end else if (state_d == RUN && count_d < CW'(2)) begin
            req_d  = 1'b1;
            addr_d = fetch_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            fetch_q <= RESET_PC;
            addr_q  <= RESET_PC;
            req_q   <= 1'b0;
            count_q <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            mem_q[0] <= '0;
            mem_q[1] <= '0;
        end else begin
            state_q <= state_d;
            fetch_q <= fetch_d;
            addr_q  <= addr_d;
            req_q   <= req_d;
            count_q <= count_d;
            if (clear) begin
                rd_q <= 1'b0;
                wr_q <= 1'b0;
            end else begin
                if (push) begin
                    mem_q[wr_q] <= '{pc: fetch_q, inst: imem.rdata};
                    wr_q        <= ~wr_q;
                end
                if (pop) rd_q <= ~rd_q;
            end
        end
    end

    assign head       = mem_q[rd_q];
    assign inst_valid = (count_q != '0);
    assign PC_if      = inst_valid ? head.pc   : '0;
    assign inst_in    = inst_valid ? head.inst : '0;
    assign imem.req   = req_q;
    assign imem.addr  = addr_q;
endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed vector table, async-reset sequence, then random
// traffic checked against a queue-based fetch model.
module tb_if_stage;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [31:0] PC_if, inst_in;
    logic        inst_valid;

    if_stage_if bus ();

    if_stage #(.RESET_PC(32'h0), .PC_INC(32'd1)) dut (
        .clk(clk), .rst_n(rst_n), .imem(bus.master),
        .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .PC_if(PC_if), .inst_in(inst_in), .inst_valid(inst_valid)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        stall, redir;
        logic [31:0] rpc;
        logic        ack;
        logic [31:0] rdata;
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] pc, inst;
    } vec_t;

    function automatic vec_t mk(input logic s, input logic r, input logic [31:0] rp,
                                input logic a, input logic [31:0] rd, input logic q,
                                input logic [31:0] ad, input logic v,
                                input logic [31:0] p, input logic [31:0] i);
        vec_t t;
        t.stall = s; t.redir = r; t.rpc = rp; t.ack = a; t.rdata = rd;
        t.req = q; t.addr = ad; t.valid = v; t.pc = p; t.inst = i;
        return t;
    endfunction

    // Reference model: what has been fetched and not consumed, plus the in-flight read.
    typedef struct packed { logic [31:0] pc; logic [31:0] inst; } ent_t;
    ent_t        q[$];
    bit          m_first, m_busy, m_drop;
    logic [31:0] m_pc, m_addr;

    task automatic model_reset();
        q.delete();
        m_first = 1; m_busy = 0; m_drop = 0; m_pc = 32'h0; m_addr = 32'h0;
    endtask

    task automatic model_step(input logic s, input logic r, input logic [31:0] rp,
                              input logic a, input logic [31:0] rd);
        bit got;
        got = m_busy && a;
        if (m_first) begin
            m_first = 0;
            if (r) m_pc = rp;
        end else if (r) begin
            q.delete();
            m_pc = rp;
            if (m_drop) begin
                if (got) m_drop = 0;
            end else if (m_busy && !got) begin
                m_drop = 1;
            end
        end else begin
            if (q.size() > 0 && !s) void'(q.pop_front());
            if (m_drop) begin
                if (got) m_drop = 0;
            end else if (got) begin
                q.push_back('{pc: m_pc, inst: rd});
                m_pc = m_pc + 32'd1;
            end
        end
        if (m_busy && !got) begin
            m_busy = 1;
        end else if (!m_drop && q.size() < 2) begin
            m_busy = 1;
            m_addr = m_pc;
        end else begin
            m_busy = 0;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req"},   32'(bus.req), 32'h0);
        check({tag, "_addr"},  bus.addr, 32'h0);
        check({tag, "_valid"}, 32'(inst_valid), 32'h0);
        check({tag, "_inst"},  inst_in, 32'h0);
        check({tag, "_pc"},    PC_if, 32'h0);
    endtask

    vec_t tbl [22];

    initial begin
        bus.ack = 1'b0;
        bus.rdata = '0;

        tbl[0]  = mk(0,0,0,           1,32'h0,     1,32'h0,       0,32'h0,       32'h0);
        tbl[1]  = mk(0,0,0,           1,32'h100,   1,32'h1,       1,32'h0,       32'h100);
        tbl[2]  = mk(0,0,0,           1,32'h101,   1,32'h2,       1,32'h1,       32'h101);
        tbl[3]  = mk(0,0,0,           1,32'h102,   1,32'h3,       1,32'h2,       32'h102);
        tbl[4]  = mk(1,0,0,           1,32'h103,   0,32'h3,       1,32'h2,       32'h102);
        tbl[5]  = mk(1,0,0,           1,32'hDEAD,  0,32'h3,       1,32'h2,       32'h102);
        tbl[6]  = mk(1,0,0,           1,32'hDEAD,  0,32'h3,       1,32'h2,       32'h102);
        tbl[7]  = mk(1,0,0,           1,32'hDEAD,  0,32'h3,       1,32'h2,       32'h102);
        tbl[8]  = mk(1,0,0,           1,32'hDEAD,  0,32'h3,       1,32'h2,       32'h102);
        tbl[9]  = mk(0,0,0,           1,32'hDEAD,  1,32'h4,       1,32'h3,       32'h103);
        tbl[10] = mk(0,0,0,           1,32'h104,   1,32'h5,       1,32'h4,       32'h104);
        tbl[11] = mk(0,1,32'h40,      1,32'h105,   1,32'h40,      0,32'h0,       32'h0);
        tbl[12] = mk(0,0,0,           1,32'h140,   1,32'h41,      1,32'h40,      32'h140);
        tbl[13] = mk(0,1,32'hFFFFFFFF,1,32'h141,   1,32'hFFFFFFFF,0,32'h0,       32'h0);
        tbl[14] = mk(0,0,0,           1,32'hF0,    1,32'h0,       1,32'hFFFFFFFF,32'hF0);
        tbl[15] = mk(0,0,0,           1,32'hF1,    1,32'h1,       1,32'h0,       32'hF1);
        tbl[16] = mk(0,0,0,           0,32'h0,     1,32'h1,       0,32'h0,       32'h0);
        tbl[17] = mk(0,1,32'h40,      0,32'h0,     1,32'h1,       0,32'h0,       32'h0);
        tbl[18] = mk(0,0,0,           0,32'h0,     1,32'h1,       0,32'h0,       32'h0);
        tbl[19] = mk(0,0,0,           0,32'h0,     1,32'h1,       0,32'h0,       32'h0);
        tbl[20] = mk(0,0,0,           1,32'hBAD,   1,32'h40,      0,32'h0,       32'h0);
        tbl[21] = mk(0,0,0,           1,32'h240,   1,32'h41,      1,32'h40,      32'h240);

        repeat (2) @(posedge clk);
        #1 check_reset_outputs("reset");
        @(negedge clk) rst_n = 1'b1;

        for (int i = 0; i < 22; i++) begin
            stall = tbl[i].stall; redirect = tbl[i].redir; redirect_pc = tbl[i].rpc;
            bus.ack = tbl[i].ack; bus.rdata = tbl[i].rdata;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_req", i), 32'(bus.req), 32'(tbl[i].req));
            if (tbl[i].req) check($sformatf("vec%0d_addr", i), bus.addr, tbl[i].addr);
            check($sformatf("vec%0d_valid", i), 32'(inst_valid), 32'(tbl[i].valid));
            check($sformatf("vec%0d_pc", i), PC_if, tbl[i].pc);
            check($sformatf("vec%0d_inst", i), inst_in, tbl[i].inst);
        end

        // Async reset with one FIFO entry and a request in flight, then a late ack.
        stall = 1'b0; redirect = 1'b0; bus.ack = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("async_rst");
        @(negedge clk);
        rst_n = 1'b1; bus.ack = 1'b1; bus.rdata = 32'h777;
        @(posedge clk);
        #1;
        check("late_ack_req", 32'(bus.req), 32'h1);
        check("late_ack_addr", bus.addr, 32'h0);
        check("late_ack_valid", 32'(inst_valid), 32'h0);
        @(posedge clk);
        #1;
        check("first_fetch_valid", 32'(inst_valid), 32'h1);
        check("first_fetch_pc", PC_if, 32'h0);
        check("first_fetch_inst", inst_in, 32'h777);

        // Randomised traffic against the model.
        @(negedge clk) rst_n = 1'b0;
        bus.ack = 1'b0; stall = 1'b0; redirect = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        model_reset();
        for (int n = 0; n < 4000; n++) begin
            stall       = ($urandom_range(99) < 30);
            redirect    = ($urandom_range(99) < 8);
            redirect_pc = ($urandom_range(3) == 0) ? (32'hFFFF_FFFE + 32'($urandom_range(1)))
                                                   : $urandom;
            bus.ack     = ($urandom_range(99) < 60);
            bus.rdata   = $urandom;
            @(posedge clk);
            model_step(stall, redirect, redirect_pc, bus.ack, bus.rdata);
            #1;
            check("rnd_req", 32'(bus.req), 32'(m_busy));
            if (m_busy) check("rnd_addr", bus.addr, m_addr);
            check("rnd_valid", 32'(inst_valid), 32'(q.size() > 0));
            check("rnd_pc", PC_if, (q.size() > 0) ? q[0].pc : 32'h0);
            check("rnd_inst", inst_in, (q.size() > 0) ? q[0].inst : 32'h0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
